alu_exec_unit: RTL and testbench

Multicycle execution unit on the consumer side of the 6-bit `alucontrol` bus produced by the ALU decoder. It executes every function code the decoder can emit: logic, arithmetic, compare and shift ops with one-cycle latency, plus iterative multiply and divide ops that write the HI/LO pair over 32 cycles. It sits in the execute stage, and the control path stalls on `in_ready`.

---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage unit driven by the 6-bit MIPS funct code.
// Single-cycle ops (shifts, add/sub, logic, compares, HI/LO moves) return
// their result one cycle after accept. mult/multu/div/divu iterate one
// bit per cycle for WIDTH cycles and then write the HI/LO pair.
//
// Handshake: an op is taken on a rising edge where in_valid && in_ready.
// in_ready is high only while the iterator is idle; a requester seeing
// in_ready low must hold its op. out_valid is a one-cycle pulse per
// accepted op with no backpressure.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready op handshake
//   alucontrol        function code (MIPS funct encoding)
//   srca, srcb, shamt operands (rs, rt, immediate shift amount)
//   out_valid         result/zero/overflow valid pulse
//   result, zero      registered result and its zero flag
//   overflow          signed overflow of add/sub
//   hi, lo            HI/LO architectural registers
//   busy              multiply/divide in progress
//   state             FSM state (IDLE=0, MUL=1, DIV=2) for observation
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [CW-1:0]      cnt;
  // Shared iteration register: multiply keeps {partial high, multiplier},
  // divide keeps {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   save_a;  // dividend as issued, for divide-by-zero HI
  logic               neg_q;   // negate product / quotient at the end
  logic               neg_r;   // negate remainder at the end
  logic               div0;

  logic accept;
  logic is_mult, is_div, signed_op;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mult   = (alucontrol == 6'h18) || (alucontrol == 6'h19);
  assign is_div    = (alucontrol == 6'h1a) || (alucontrol == 6'h1b);
  assign signed_op = ~alucontrol[0];
  assign a_neg     = signed_op && srca[WIDTH-1];
  assign b_neg     = signed_op && srcb[WIDTH-1];
  assign mag_a     = a_neg ? (~srca + 1'b1) : srca;
  assign mag_b     = b_neg ? (~srcb + 1'b1) : srcb;

  // Single-cycle datapath
  logic [WIDTH-1:0] add_sum, sub_diff, sc_result;
  logic             add_ov, sub_ov, sc_ov;

  assign add_sum  = srca + srcb;
  assign sub_diff = srca - srcb;
  assign add_ov   = (srca[WIDTH-1] == srcb[WIDTH-1]) && (add_sum[WIDTH-1] != srca[WIDTH-1]);
  assign sub_ov   = (srca[WIDTH-1] != srcb[WIDTH-1]) && (sub_diff[WIDTH-1] != srca[WIDTH-1]);

  always_comb begin
    sc_result = '0;
    sc_ov     = 1'b0;
    case (alucontrol)
      6'h00: sc_result = srcb << shamt;
      6'h02: sc_result = srcb >> shamt;
      6'h03: sc_result = $signed(srcb) >>> shamt;
      6'h04: sc_result = srcb << srca[4:0];
      6'h06: sc_result = srcb >> srca[4:0];
      6'h07: sc_result = $signed(srcb) >>> srca[4:0];
      6'h10: sc_result = hi;
      6'h12: sc_result = lo;
      6'h20: begin sc_result = add_sum;  sc_ov = add_ov; end
      6'h21: sc_result = add_sum;
      6'h22: begin sc_result = sub_diff; sc_ov = sub_ov; end
      6'h23: sc_result = sub_diff;
      6'h24: sc_result = srca & srcb;
      6'h25: sc_result = srca | srcb;
      6'h26: sc_result = srca ^ srcb;
      6'h27: sc_result = ~(srca | srcb);
      6'h2a: sc_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      6'h2b: sc_result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      default: sc_result = '0;  // mthi/mtlo and unknown codes return 0
    endcase
  end

  // One shift-add multiply step: add multiplicand into the high half when
  // the current multiplier bit is set, then shift the whole pair right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_prod;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_prod = neg_q ? (~mul_next + 1'b1) : mul_next;

  // One restoring divide step: shift the next dividend bit into the
  // remainder, keep the subtraction only if it did not borrow.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_q, div_r, fin_hi, fin_lo;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ok};
  assign div_q     = div_next[WIDTH-1:0];
  assign div_r     = div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_hi = mul_prod[2*WIDTH-1:WIDTH];
    fin_lo = mul_prod[WIDTH-1:0];
    if (state == S_DIV) begin
      if (div0) begin
        fin_hi = save_a;
        fin_lo = '1;
      end else begin
        fin_hi = neg_r ? (~div_r + 1'b1) : div_r;
        fin_lo = neg_q ? (~div_q + 1'b1) : div_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      save_a    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mult || is_div) begin
              state  <= is_mult ? S_MUL : S_DIV;
              cnt    <= '0;
              acc    <= is_mult ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
              opb    <= is_mult ? mag_a : mag_b;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              div0   <= (srcb == '0);
              save_a <= srca;
            end else begin
              out_valid <= 1'b1;
              result    <= sc_result;
              zero      <= (sc_result == '0);
              overflow  <= sc_ov;
              if (alucontrol == 6'h11) hi <= srca;
              if (alucontrol == 6'h13) lo <= srca;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= (state == S_MUL) ? mul_next : div_next;
          cnt <= cnt + 1'b1;
          // The last iteration writes HI/LO directly so the completion
          // pulse and the return to IDLE share the same cycle.
          if (cnt == CW'(WIDTH-1)) begin
            state     <= S_IDLE;
            hi        <= fin_hi;
            lo        <= fin_lo;
            out_valid <= 1'b1;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed test-plan ops plus randomized ops,
// checked against an arithmetic reference model with an expected queue.
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   alucontrol;
  logic [W-1:0] srca, srcb;
  logic [4:0]   shamt;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero, overflow;
  logic [W-1:0] hi, lo;
  logic         busy;
  logic [1:0]   state;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo), .busy(busy), .state(state)
  );

  // Clock / reset / cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hi_q[$];
  logic [W-1:0] lo_q[$];
  logic [1:0]   flag_q[$];   // {zero, overflow}
  int           cyc_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int bs = -1, be = -1;       // cycles where in_ready must be low
  bit checking = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: spec rules in plain 64-bit arithmetic.
  function automatic void ref_op(input logic [5:0] op, input logic [31:0] a, b,
                                 input logic [4:0] sh, input logic [31:0] chi, clo,
                                 output logic [31:0] r, output logic ov,
                                 output logic [31:0] nhi, nlo, output int lat);
    longint sa, sb, s, q, rm;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0; ov = 1'b0; nhi = chi; nlo = clo; lat = 1;
    case (op)
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      6'h03: r = $signed(b) >>> sh;
      6'h04: r = b << a[4:0];
      6'h06: r = b >> a[4:0];
      6'h07: r = $signed(b) >>> a[4:0];
      6'h10: r = chi;
      6'h12: r = clo;
      6'h11: nhi = a;
      6'h13: nlo = a;
      6'h20: begin s = sa + sb; r = s[31:0]; ov = (s > MAXI) || (s < MINI); end
      6'h21: r = a + b;
      6'h22: begin s = sa - sb; r = s[31:0]; ov = (s > MAXI) || (s < MINI); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h2b: r = (ua < ub) ? 32'd1 : 32'd0;
      6'h18: begin s = sa * sb; nhi = s[63:32]; nlo = s[31:0]; lat = 33; end
      6'h19: begin up = ua * ub; nhi = up[63:32]; nlo = up[31:0]; lat = 33; end
      6'h1a: begin
        lat = 33;
        if (b == 0) begin nhi = a; nlo = '1; end
        else begin q = sa / sb; rm = sa % sb; nlo = q[31:0]; nhi = rm[31:0]; end
      end
      6'h1b: begin
        lat = 33;
        if (b == 0) begin nhi = a; nlo = '1; end
        else begin up = ua / ub; nlo = up[31:0]; up = ua % ub; nhi = up[31:0]; end
      end
      default: r = '0;
    endcase
  endfunction

  // Driver: wait (bounded) for in_ready, present the op for one edge,
  // record the model's expectation, then scramble the inputs.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    int waited = 0;
    logic [31:0] r, nhi, nlo;
    logic ov;
    int lat;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 (op %0h)", op);
      return;
    end
    ref_op(op, a, b, sh, m_hi, m_lo, r, ov, nhi, nlo, lat);
    m_hi = nhi;
    m_lo = nlo;
    exp_q.push_back(r);
    hi_q.push_back(nhi);
    lo_q.push_back(nlo);
    flag_q.push_back({(r == 0), ov});
    cyc_q.push_back(cyc + lat);
    if (lat > 1) begin bs = cyc + 1; be = cyc + 32; end
    alucontrol = op; srca = a; srcb = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    srca       = $urandom;
    srcb       = $urandom;
    shamt      = 5'($urandom);
    alucontrol = 6'($urandom);
  endtask

  // Compare process
  always @(negedge clk) begin
    if (!reset && checking) begin
      bit exp_rdy;
      exp_rdy = !(cyc >= bs && cyc <= be);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(!exp_rdy));
      if (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
        total++; bad++;
        $display("FAIL out_valid_missing: got 0 expected 1 at cycle %0d", cyc_q[0]);
        void'(exp_q.pop_front()); void'(hi_q.pop_front());
        void'(lo_q.pop_front()); void'(flag_q.pop_front()); void'(cyc_q.pop_front());
      end
      if (out_valid) begin
        if (cyc_q.size() == 0 || cyc_q[0] != cyc) begin
          total++; bad++;
          $display("FAIL out_valid_spurious: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          logic [1:0] f;
          f = flag_q.pop_front();
          void'(cyc_q.pop_front());
          chk("result", 64'(result), 64'(exp_q.pop_front()));
          chk("zero", 64'(zero), 64'(f[1]));
          chk("overflow", 64'(overflow), 64'(f[0]));
          chk("hi", 64'(hi), 64'(hi_q.pop_front()));
          chk("lo", 64'(lo), 64'(lo_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] op_pool[24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                              6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h1a, 6'h3f};

  initial begin
    logic [31:0] r, nhi, nlo;
    logic ov;
    int lat;

    reset = 1'b1; in_valid = 1'b0; alucontrol = '0;
    srca = '0; srcb = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_zero", 64'(zero), 64'h1);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;
    checking = 1;

    // Hand-computed values pinning the model.
    ref_op(6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_add", {31'd0, ov, r}, {31'd0, 1'b1, 32'h80000000});
    ref_op(6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_addu_ov", 64'(ov), 64'h0);
    ref_op(6'h2a, 32'hFFFFFFFF, 32'h1, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_slt", 64'(r), 64'h1);
    ref_op(6'h2b, 32'hFFFFFFFF, 32'h1, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_sltu", 64'(r), 64'h0);
    ref_op(6'h03, 32'h0, 32'h80000000, 5'd4, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_sra", 64'(r), 64'hF8000000);
    ref_op(6'h18, 32'hFFFFFFFE, 32'h3, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_mult", {nhi, nlo}, 64'hFFFFFFFF_FFFFFFFA);
    ref_op(6'h19, 32'hFFFFFFFE, 32'h3, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_multu", {nhi, nlo}, 64'h00000002_FFFFFFFA);
    ref_op(6'h1a, 32'hFFFFFFF9, 32'h2, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_div", {nhi, nlo}, 64'hFFFFFFFF_FFFFFFFD);
    ref_op(6'h1b, 32'd10, 32'd0, 5'd0, 0, 0, r, ov, nhi, nlo, lat);
    chk("pin_divu0", {nhi, nlo}, 64'h0000000A_FFFFFFFF);

    // Directed test-plan sequence through the DUT.
    issue(6'h20, 32'h7FFFFFFF, 32'h1, 5'd0);
    issue(6'h21, 32'h7FFFFFFF, 32'h1, 5'd0);
    issue(6'h22, 32'd5, 32'd5, 5'd0);
    issue(6'h2a, 32'hFFFFFFFF, 32'h1, 5'd0);
    issue(6'h2b, 32'hFFFFFFFF, 32'h1, 5'd0);
    issue(6'h03, 32'h0, 32'h80000000, 5'd4);
    issue(6'h18, 32'hFFFFFFFE, 32'h3, 5'd0);
    issue(6'h19, 32'hFFFFFFFE, 32'h3, 5'd0);
    issue(6'h1a, 32'hFFFFFFF9, 32'h2, 5'd0);
    issue(6'h1b, 32'd10, 32'd0, 5'd0);
    issue(6'h11, 32'h1234, 32'h0, 5'd0);
    issue(6'h13, 32'h5678, 32'h0, 5'd0);
    issue(6'h10, 32'h0, 32'h0, 5'd0);
    issue(6'h12, 32'h0, 32'h0, 5'd0);
    issue(6'h18, 32'd3, 32'd4, 5'd0);
    issue(6'h10, 32'h0, 32'h0, 5'd0);   // accepted in the completion cycle

    // Reset in the middle of a divu.
    issue(6'h1b, 32'd1000, 32'd7, 5'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); hi_q.delete(); lo_q.delete(); flag_q.delete(); cyc_q.delete();
    m_hi = '0; m_lo = '0; bs = -1; be = -1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h0);
    chk("abort_in_ready", 64'(in_ready), 64'h1);
    chk("abort_out_valid", 64'(out_valid), 64'h0);
    repeat (30) @(negedge clk);
    issue(6'h3f, 32'hDEADBEEF, 32'h12345678, 5'd3);

    // Randomized ops.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      op = op_pool[$urandom_range(0, 23)];
      if (op == 6'h1a && $urandom_range(0, 1) == 0) op = 6'h1b;
      issue(op, pick(), pick(), 5'($urandom));
    end

    repeat (40) @(negedge clk);
    chk("drain", 64'(cyc_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
